// File: rtl/ro_ctrl_pkg.sv
// Shared definitions for the ring-oscillator sensor sequencer: command
// byte codes, FSM state encoding and timer width.
package ro_ctrl_pkg;

    localparam logic [7:0] CMD_SINGLE     = 8'h00;
    localparam logic [7:0] CMD_CHSEL_BASE = 8'h10;
    localparam logic [7:0] CMD_CONT       = 8'h20;
    localparam logic [7:0] CMD_STOP       = 8'h21;
    localparam logic [7:0] CMD_SCAN       = 8'h22;

    localparam int TIMER_W = 16;
    localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
    localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

    // A 0x1n byte selects channel n only when that channel exists.
    function automatic logic is_chsel_cmd(input logic [7:0] cmd, input int num_ch);
        return (cmd[7:4] == CMD_CHSEL_BASE[7:4]) && (int'(cmd[3:0]) < num_ch);
    endfunction

endpackage

// File: rtl/ro_ctrl_cmd_buf.sv
// Command register plus a one-deep pending slot. Bytes that arrive while a
// frame is on the wire are parked (newest wins) and handed to the command
// register when the FSM asks for them with consume.
module ro_ctrl_cmd_buf
    import ro_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       hold_pend,
    input  logic       consume,
    output logic [7:0] cmd,
    output logic       pend_valid
);

    logic [7:0] cmd_r;
    logic [7:0] pend_r;
    logic       pend_valid_r;

    // Capture bytes into the command or pending register; a byte arriving in
    // the consume cycle is newer than the parked one and takes its place.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_r        <= CMD_SINGLE;
            pend_r       <= 8'h00;
            pend_valid_r <= 1'b0;
        end else if (consume) begin
            cmd_r        <= rx_ready ? rx_data : pend_r;
            pend_valid_r <= 1'b0;
        end else if (rx_ready && hold_pend) begin
            pend_r       <= rx_data;
            pend_valid_r <= 1'b1;
        end else if (rx_ready) begin
            cmd_r        <= rx_data;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    assign cmd        = cmd_r;
    assign pend_valid = pend_valid_r;

endmodule

// File: rtl/ro_sensor_ctrl.sv
// Command / measure / transmit sequencer for the RO temperature sensor.
// Decodes UART command bytes, drives the adder enable and channel select,
// and paces a NUM_BYTES result frame out through the UART transmitter.
module ro_sensor_ctrl
    import ro_ctrl_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int NUM_BYTES    = 3,
    parameter int TX_GAP       = 100,
    parameter int MEAS_TIMEOUT = 65535
) (
    input  logic                                               clk,
    input  logic                                               reset_n,
    input  logic                                               rx_ready,
    input  logic [7:0]                                         rx_data,
    input  logic                                               sum_ready,
    input  logic                                               tx_busy,
    output logic                                               sum_en,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]     ch_sel,
    output logic                                               tx_send,
    output logic [((NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1)-1:0] send_sel,
    output logic                                               busy,
    output logic                                               cont_mode,
    output logic                                               timeout_err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SS_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [TIMER_W-1:0] MEAS_LAST = TIMER_W'(MEAS_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(TX_GAP - 1);
    localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [SS_W-1:0]    SEL_LAST  = SS_W'(NUM_BYTES - 1);

    state_t              st_r, st_nx_s;
    logic [TIMER_W-1:0]  timer_r;
    logic                sum_en_r, tx_send_r, busy_r;
    logic                cont_r, scan_r, to_err_r;
    logic [CH_W-1:0]     ch_r;
    logic [SS_W-1:0]     sel_r;
    logic [7:0]          cmd_s;
    logic                pend_valid_s, hold_pend_s, consume_s;
    logic                next_byte_s, frame_done_s, meas_to_s;
    logic                gap_ok_s, last_byte_s, is_meas_cmd_s;

    assign hold_pend_s   = (st_r == ST_SEND) || (st_r == ST_WAIT_TX);
    assign gap_ok_s      = (timer_r >= GAP_LAST) && !tx_busy;
    assign last_byte_s   = (sel_r == SEL_LAST);
    assign is_meas_cmd_s = (cmd_s == CMD_SINGLE) || (cmd_s == CMD_CONT) || (cmd_s == CMD_SCAN);

    ro_ctrl_cmd_buf u_cmd_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .hold_pend  (hold_pend_s),
        .consume    (consume_s),
        .cmd        (cmd_s),
        .pend_valid (pend_valid_s)
    );

    // Next-state logic and single-cycle action strobes.
    always_comb begin
        st_nx_s      = st_r;
        consume_s    = 1'b0;
        next_byte_s  = 1'b0;
        frame_done_s = 1'b0;
        meas_to_s    = 1'b0;
        case (st_r)
            ST_IDLE: begin
                if (rx_ready || pend_valid_s) begin
                    st_nx_s   = ST_DECODE;
                    consume_s = pend_valid_s;
                end else begin
                    st_nx_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (is_meas_cmd_s) begin
                    st_nx_s = ST_MEASURE;
                end else begin
                    st_nx_s = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                // A new command aborts the measurement, even if the sum lands now.
                if (rx_ready) begin
                    st_nx_s = ST_DECODE;
                end else if (sum_ready) begin
                    st_nx_s = ST_SEND;
                end else if (timer_r == MEAS_LAST) begin
                    st_nx_s   = ST_IDLE;
                    meas_to_s = 1'b1;
                end else begin
                    st_nx_s = ST_MEASURE;
                end
            end
            ST_SEND: begin
                st_nx_s = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (!gap_ok_s) begin
                    st_nx_s = ST_WAIT_TX;
                end else if (!last_byte_s) begin
                    st_nx_s     = ST_SEND;
                    next_byte_s = 1'b1;
                end else begin
                    frame_done_s = 1'b1;
                    if (!cont_r) begin
                        st_nx_s = ST_IDLE;
                    end else if (pend_valid_s || rx_ready) begin
                        st_nx_s   = ST_DECODE;
                        consume_s = 1'b1;
                    end else begin
                        st_nx_s = ST_MEASURE;
                    end
                end
            end
            default: begin
                st_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register, per-state timer and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_r      <= ST_IDLE;
            timer_r   <= TIMER_ZERO;
            sum_en_r  <= 1'b0;
            tx_send_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            st_r      <= st_nx_s;
            sum_en_r  <= (st_nx_s == ST_MEASURE);
            tx_send_r <= (st_nx_s == ST_SEND);
            busy_r    <= (st_nx_s != ST_IDLE);
            if (st_nx_s != st_r) begin
                timer_r <= TIMER_ZERO;
            end else if (timer_r != TIMER_MAX) begin
                timer_r <= timer_r + TIMER_ONE;
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Mode flags, channel select, error flag and byte index.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cont_r   <= 1'b0;
            scan_r   <= 1'b0;
            to_err_r <= 1'b0;
            ch_r     <= {CH_W{1'b0}};
            sel_r    <= {SS_W{1'b0}};
        end else if (st_r == ST_DECODE) begin
            case (cmd_s)
                CMD_SINGLE: begin
                    cont_r   <= 1'b0;
                    scan_r   <= 1'b0;
                    to_err_r <= 1'b0;
                end
                CMD_CONT: begin
                    cont_r   <= 1'b1;
                    scan_r   <= 1'b0;
                    to_err_r <= 1'b0;
                end
                CMD_SCAN: begin
                    cont_r   <= 1'b1;
                    scan_r   <= 1'b1;
                    to_err_r <= 1'b0;
                end
                CMD_STOP: begin
                    cont_r <= 1'b0;
                    scan_r <= 1'b0;
                end
                default: begin
                    if (is_chsel_cmd(cmd_s, NUM_CH)) begin
                        ch_r     <= CH_W'(cmd_s[3:0]);
                        to_err_r <= 1'b0;
                    end else begin
                        ch_r <= ch_r;
                    end
                end
            endcase
        end else if (meas_to_s) begin
            to_err_r <= 1'b1;
            cont_r   <= 1'b0;
            scan_r   <= 1'b0;
        end else if (frame_done_s) begin
            sel_r <= {SS_W{1'b0}};
            if (scan_r) begin
                ch_r <= (ch_r == CH_LAST) ? {CH_W{1'b0}} : ch_r + CH_W'(1);
            end else begin
                ch_r <= ch_r;
            end
        end else if (next_byte_s) begin
            sel_r <= sel_r + SS_W'(1);
        end else begin
            sel_r <= sel_r;
        end
    end

    assign sum_en      = sum_en_r;
    assign tx_send     = tx_send_r;
    assign busy        = busy_r;
    assign ch_sel      = ch_r;
    assign send_sel    = sel_r;
    assign cont_mode   = cont_r;
    assign timeout_err = to_err_r;

endmodule

// File: tb/tb_ro_sensor_ctrl.sv
// Self-checking bench for ro_sensor_ctrl: command table, hand-written
// frame/scan/timeout/abort/reset sequences and a randomized command stream
// checked against a transaction-level expectation of channel and frames.
module tb_ro_sensor_ctrl;

    localparam int NUM_CH       = 4;
    localparam int NUM_BYTES    = 3;
    localparam int TX_GAP       = 100;
    localparam int MEAS_TIMEOUT = 200;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       rx_ready  = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       sum_ready = 1'b0;
    logic       tx_busy   = 1'b0;
    logic       sum_en, tx_send, busy, cont_mode, timeout_err;
    logic [1:0] ch_sel, send_sel;

    typedef struct { int sel; int ch; longint cyc; } tx_rec_t;
    typedef struct { logic [7:0] cmd; int exp_ch; } vec_t;

    tx_rec_t    txq[$];
    vec_t       vecs[10];
    logic [7:0] junk[6];
    longint     cyc = 0;
    int         busy_len = 0;
    int         checks = 0;
    int         errors = 0;
    int         m_ch = 0;

    ro_sensor_ctrl #(
        .NUM_CH       (NUM_CH),
        .NUM_BYTES    (NUM_BYTES),
        .TX_GAP       (TX_GAP),
        .MEAS_TIMEOUT (MEAS_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .sum_ready   (sum_ready),
        .tx_busy     (tx_busy),
        .sum_en      (sum_en),
        .ch_sel      (ch_sel),
        .tx_send     (tx_send),
        .send_sel    (send_sel),
        .busy        (busy),
        .cont_mode   (cont_mode),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every transmit strobe with its byte index, channel and cycle.
    always @(negedge clk) begin
        if (tx_send) txq.push_back('{sel: int'(send_sel), ch: int'(ch_sel), cyc: cyc});
    end

    // UART transmitter stand-in: busy for busy_len cycles after each strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_send) begin
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_sum(input string tag);
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        chk({tag, "_tx_latency"}, tx_send, 1);
        chk({tag, "_first_sel"}, send_sel, 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_sum_en(input string tag);
        int n;
        n = 0;
        while (sum_en !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_sum_en"}, sum_en, 1);
    endtask

    task automatic expect_frame(input int exp_ch, input string tag);
        int      n;
        int      gap;
        longint  prev;
        tx_rec_t r;
        n    = 0;
        prev = 0;
        gap  = (busy_len + 1 > TX_GAP + 1) ? busy_len + 1 : TX_GAP + 1;
        while (txq.size() < NUM_BYTES && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_frame_bytes"}, txq.size(), NUM_BYTES);
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (txq.size() != 0) begin
                r = txq.pop_front();
                chk($sformatf("%s_sel%0d", tag, i), r.sel, i);
                chk($sformatf("%s_ch%0d", tag, i), r.ch, exp_ch);
                if (i > 0) chk($sformatf("%s_gap%0d", tag, i), r.cyc - prev, gap);
                prev = r.cyc;
            end
        end
    endtask

    initial begin
        int kind;
        int nib;
        vecs[0] = '{cmd: 8'h12, exp_ch: 2};
        vecs[1] = '{cmd: 8'h17, exp_ch: 2};
        vecs[2] = '{cmd: 8'h13, exp_ch: 3};
        vecs[3] = '{cmd: 8'h14, exp_ch: 3};
        vecs[4] = '{cmd: 8'h10, exp_ch: 0};
        vecs[5] = '{cmd: 8'h55, exp_ch: 0};
        vecs[6] = '{cmd: 8'h11, exp_ch: 1};
        vecs[7] = '{cmd: 8'h21, exp_ch: 1};
        vecs[8] = '{cmd: 8'hFF, exp_ch: 1};
        vecs[9] = '{cmd: 8'h12, exp_ch: 2};
        junk[0] = 8'h21; junk[1] = 8'h23; junk[2] = 8'h30;
        junk[3] = 8'h01; junk[4] = 8'h1F; junk[5] = 8'h80;

        // Reset values
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_sum_en", sum_en, 0);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_send_sel", send_sel, 0);
        chk("rst_ch_sel", ch_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cont", cont_mode, 0);
        chk("rst_timeout", timeout_err, 0);

        // Single shot, sum 20 cycles in, transmitter busy 50 cycles per byte
        busy_len = 50;
        send_cmd(8'h00);
        chk("t1_decode_busy", busy, 1);
        chk("t1_decode_sum_en", sum_en, 0);
        @(negedge clk);
        chk("t1_meas_sum_en", sum_en, 1);
        repeat (19) @(negedge clk);
        pulse_sum("t1");
        expect_frame(0, "t1");
        wait_idle("t1");
        chk("t1_cont", cont_mode, 0);
        chk("t1_extra_tx", txq.size(), 0);

        // Command table from IDLE
        foreach (vecs[i]) begin
            send_cmd(vecs[i].cmd);
            repeat (2) @(negedge clk);
            chk($sformatf("tbl%0d_ch", i), ch_sel, vecs[i].exp_ch);
            chk($sformatf("tbl%0d_busy", i), busy, 0);
        end
        m_ch = 2;
        send_cmd(8'h00);
        @(negedge clk);
        chk("t2_meas_ch", ch_sel, 2);
        pulse_sum("t2");
        expect_frame(2, "t2");
        wait_idle("t2");

        // Scan: channels 0,1,2,3,0, stop arrives mid-frame
        busy_len = 20;
        send_cmd(8'h10);
        repeat (2) @(negedge clk);
        send_cmd(8'h22);
        for (int f = 0; f < 5; f++) begin
            wait_sum_en("t3");
            chk("t3_cont", cont_mode, 1);
            pulse_sum("t3");
            if (f == 4) send_cmd(8'h21);
            expect_frame(f % NUM_CH, "t3");
        end
        wait_idle("t3");
        chk("t3_cont_cleared", cont_mode, 0);
        chk("t3_ch_after_scan", ch_sel, 1);
        m_ch = 1;
        repeat (300) @(negedge clk);
        chk("t3_extra_tx", txq.size(), 0);
        chk("t3_no_meas", sum_en, 0);

        // Measurement timeout
        send_cmd(8'h00);
        @(negedge clk);
        chk("t4_first_meas", sum_en, 1);
        repeat (MEAS_TIMEOUT - 1) @(negedge clk);
        chk("t4_last_meas", sum_en, 1);
        @(negedge clk);
        chk("t4_idle", busy, 0);
        chk("t4_err_set", timeout_err, 1);
        chk("t4_sum_en_off", sum_en, 0);
        chk("t4_no_tx", txq.size(), 0);
        send_cmd(8'h00);
        chk("t4_err_in_decode", timeout_err, 1);
        @(negedge clk);
        chk("t4_err_cleared", timeout_err, 0);
        pulse_sum("t4");
        expect_frame(m_ch, "t4");
        wait_idle("t4");

        // Command and sum_ready in the same MEASURE cycle
        send_cmd(8'h00);
        repeat (3) @(negedge clk);
        rx_data   = 8'h21;
        rx_ready  = 1'b1;
        sum_ready = 1'b1;
        @(negedge clk);
        rx_ready  = 1'b0;
        sum_ready = 1'b0;
        chk("t5_no_tx", tx_send, 0);
        chk("t5_decode_busy", busy, 1);
        chk("t5_sum_en_off", sum_en, 0);
        @(negedge clk);
        chk("t5_idle", busy, 0);
        repeat (250) @(negedge clk);
        chk("t5_extra_tx", txq.size(), 0);

        // Randomized command stream
        for (int it = 0; it < 40; it++) begin
            kind     = $urandom_range(0, 3);
            busy_len = $urandom_range(0, 150);
            nib      = $urandom_range(0, 7);
            case (kind)
                0, 3: begin
                    send_cmd(8'h00);
                    @(negedge clk);
                    repeat ($urandom_range(0, 40)) @(negedge clk);
                    pulse_sum("rnd");
                    if (kind == 3) send_cmd(8'h10 | 8'(nib));
                    expect_frame(m_ch, "rnd");
                    wait_idle("rnd");
                    repeat (3) @(negedge clk);
                    if (kind == 3 && nib < NUM_CH) m_ch = nib;
                    chk("rnd_ch", ch_sel, m_ch);
                    chk("rnd_busy", busy, 0);
                    chk("rnd_timeout", timeout_err, 0);
                    chk("rnd_cont", cont_mode, 0);
                    chk("rnd_extra_tx", txq.size(), 0);
                end
                1: begin
                    send_cmd(8'h10 | 8'(nib));
                    if (nib < NUM_CH) m_ch = nib;
                    repeat (2) @(negedge clk);
                    chk("rnd_chsel_ch", ch_sel, m_ch);
                    chk("rnd_chsel_busy", busy, 0);
                end
                default: begin
                    send_cmd(junk[nib % 6]);
                    repeat (2) @(negedge clk);
                    chk("rnd_junk_ch", ch_sel, m_ch);
                    chk("rnd_junk_busy", busy, 0);
                    chk("rnd_junk_cont", cont_mode, 0);
                end
            endcase
        end

        // Reset during WAIT_TX with a command parked
        busy_len = 10;
        send_cmd(8'h13);
        repeat (2) @(negedge clk);
        send_cmd(8'h00);
        @(negedge clk);
        pulse_sum("t6");
        begin
            int n;
            n = 0;
            while (txq.size() < 2 && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        send_cmd(8'h11);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_sum_en", sum_en, 0);
        chk("t6_tx_send", tx_send, 0);
        chk("t6_send_sel", send_sel, 0);
        chk("t6_ch_sel", ch_sel, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cont", cont_mode, 0);
        chk("t6_timeout", timeout_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        txq.delete();
        repeat (300) @(negedge clk);
        chk("t6_no_tx", txq.size(), 0);
        chk("t6_pend_dropped_ch", ch_sel, 0);
        chk("t6_pend_dropped_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_sensor_ctrl.md
# ro_sensor_ctrl

Parametrised command/measurement/transmit sequencer for the ring-oscillator temperature sensor. Sits between the UART receiver/transmitter and the RO counter/adder: decodes single-byte UART commands, selects one of NUM_CH oscillator channels, enables the adder, and ships a NUM_BYTES result frame byte by byte. Adds single-shot, continuous and auto-scan modes, tx_busy-qualified pacing, a measurement timeout and one-deep command buffering during transmission.

## Interface
- NUM_CH, 4: RO channels, 1..16.
- NUM_BYTES, 3: bytes per result frame, 1..8.
- TX_GAP, 100: minimum cycles from tx_send to the next byte, 1..65535.
- MEAS_TIMEOUT, 65535: cycles allowed in MEASURE for sum_ready, 1..65535.
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- rx_ready  in  1  one-cycle strobe: rx_data valid.
- rx_data  in  8  received command byte.
- sum_ready  in  1  adder result valid (level or pulse).
- tx_busy  in  1  UART transmitter busy.
- sum_en  out  1  adder enable.
- ch_sel  out  max(1,$clog2(NUM_CH))  active channel.
- tx_send  out  1  one-cycle transmit strobe.
- send_sel  out  max(1,$clog2(NUM_BYTES))  byte index of frame being sent.
- busy  out  1  high in any state except IDLE.
- cont_mode  out  1  continuous (or scan) mode active.
- timeout_err  out  1  sticky: a measurement timed out.

## Operation
- Commands (latched into cmd_reg on rx_ready): 0x00 single shot; 0x1n select channel n (ignored if n >= NUM_CH); 0x20 continuous; 0x21 stop; 0x22 continuous scan. All others ignored, no state change.
- States: IDLE, DECODE, MEASURE, SEND, WAIT_TX.
- IDLE: rx_ready -> DECODE. If pend_valid, consume pending -> DECODE.
- DECODE (1 cycle): 0x00/0x20/0x22 -> MEASURE, clear timeout_err, set cont_mode for 0x20/0x22 (scan flag for 0x22), clear for 0x00. 0x1n -> update ch_sel, clear timeout_err, -> IDLE. 0x21 -> clear cont_mode/scan -> IDLE. Invalid -> IDLE.
- MEASURE: sum_en=1. rx_ready -> DECODE (aborts measurement; has priority over sum_ready same cycle). Else sum_ready -> SEND with send_sel=0. Else timer reaches MEAS_TIMEOUT-1 -> set timeout_err, clear cont_mode/scan, -> IDLE.
- SEND (1 cycle): tx_send=1 -> WAIT_TX.
- WAIT_TX: exit when timer >= TX_GAP-1 and tx_busy=0. If send_sel < NUM_BYTES-1: increment send_sel -> SEND. Else frame done: send_sel->0; if scan, ch_sel <= (ch_sel==NUM_CH-1)?0:ch_sel+1; if cont_mode -> MEASURE (unless pend_valid, then -> DECODE); else -> IDLE.
- rx_ready in SEND/WAIT_TX: stored in pend register (pend_valid=1); later byte overwrites earlier. Consumed only after frame completes. Frames are never truncated.
- send_sel held at current index through SEND and WAIT_TX; 0 elsewhere.

## Timing
- Reset values: state IDLE, sum_en 0, tx_send 0, send_sel 0, ch_sel 0, busy 0, cont_mode 0, timeout_err 0, pend_valid 0, timer 0.
- Outputs Moore, decoded from registered state/registers; no combinational input-to-output path.
- Timer 16 bit: cleared on every state change, else increments, saturates at 0xFFFF.
- rx_ready at edge k in IDLE -> DECODE at k+1 -> MEASURE, sum_en high from k+2.
- sum_ready at edge m in MEASURE -> tx_send high exactly cycle m+1.
- Byte spacing: at least TX_GAP+1 cycles between tx_send strobes; longer while tx_busy stays high.
- Reset asserted mid-operation: all registers to reset values at next edge; pending command dropped; no tx_send emitted.
- NUM_BYTES=1: send_sel constant 0, single SEND/WAIT_TX per frame. NUM_CH=1: 0x10 valid, scan leaves ch_sel 0.

## Structure
- Package ro_ctrl_pkg: command codes (CMD_SINGLE, CMD_CHSEL_BASE, CMD_CONT, CMD_STOP, CMD_SCAN), state encoding, timer width constant.
- Sub-module ro_ctrl_cmd_buf: cmd_reg plus one-deep pending register with overwrite and consume handshake; FSM, timer and counters stay in top.

## Test plan
- Reset, send 0x00, sum_ready 20 cycles later, tx_busy high 50 cycles per byte, NUM_BYTES=3 -> three tx_send pulses with send_sel 0,1,2, spacing >= 101 cycles, then IDLE, busy 0.
- Send 0x12 then 0x00 with NUM_CH=4 -> ch_sel=2 during measurement; send 0x17 -> ch_sel unchanged.
- Send 0x22, sum_ready each pass -> frames repeat, ch_sel 0,1,2,3,0; send 0x21 mid-frame -> current frame completes, then IDLE.
- Send 0x00, hold sum_ready low, MEAS_TIMEOUT=200 -> IDLE after 200 MEASURE cycles, timeout_err=1, no tx_send; next 0x00 clears it.
- rx_ready=0x21 and sum_ready same cycle in MEASURE -> DECODE, no tx_send; reset_n low during WAIT_TX -> all outputs 0 next cycle.
